// File: rtl/clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_ctrl
// Brief    : Single-clock timing source for the 8-bit core. It divides clk by
//            a programmable ratio into a one-cycle tick enable and drives a
//            one-hot phase ring. It supports free-run, single-step and
//            CPU-initiated halt.
// Revision : 1.0 - initial release
// ============================================================================
module clock_ctrl #(
  parameter int DIV_W  = 16,  // divide-ratio / prescaler width
  parameter int PHASES = 2,   // one-hot phase outputs, must be >= 2
  parameter int CNT_W  = 16   // tick counter width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              step,
  input  logic              halt,
  input  logic              clear_halt,
  input  logic [DIV_W-1:0]  div,
  output logic              tick,
  output logic [PHASES-1:0] phase,
  output logic [CNT_W-1:0]  tick_count,
  output logic              running,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [PHASES-1:0] C_PHASE_RST = PHASES'(1);

  state_t            state_q,      state_d;
  logic [DIV_W-1:0]  cnt_q,        cnt_d;
  logic              tick_q,       tick_d;
  logic [PHASES-1:0] phase_q,      phase_d;
  logic [CNT_W-1:0]  tick_count_q, tick_count_d;
  logic              step_q,       step_d;
  logic              running_q,    running_d;
  logic              halted_q,     halted_d;

  logic              step_edge;
  logic              div_hit;

  assign step_edge = step & ~step_q;
  // The >= compare lets a lowered divisor fire at once instead of wrapping
  assign div_hit   = (cnt_q >= div);

  // Next-state, prescaler, step and phase/count logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    tick_d       = 1'b0;
    phase_d      = phase_q;
    tick_count_d = tick_count_q;
    step_d       = step;

    // State transitions in priority order; halt overrides everything
    if (halt) begin
      state_d = ST_HALTED;
    end else begin
      case (state_q)
        ST_HALTED: state_d = clear_halt ? ST_IDLE : ST_HALTED;
        ST_IDLE:   state_d = enable ? ST_RUN : ST_IDLE;
        ST_RUN:    state_d = enable ? ST_RUN : ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    // Prescaler runs only in RUN; leaving RUN restarts the period from zero
    if (state_q == ST_RUN) begin
      tick_d = div_hit;
      if (state_d == ST_RUN) begin
        cnt_d = div_hit ? '0 : cnt_q + DIV_W'(1);
      end
    end else if (state_q == ST_IDLE) begin
      // Single step only when stopped; a simultaneous enable wins
      tick_d = step_edge & ~enable;
    end

    // A sampled halt drops whatever tick was about to be issued
    if (halt) begin
      tick_d = 1'b0;
    end

    // The tick cycle that is ending advances the ring and the counter
    if (tick_q) begin
      phase_d      = {phase_q[PHASES-2:0], phase_q[PHASES-1]};
      tick_count_d = tick_count_q + CNT_W'(1);
    end

    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALTED);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      phase_q      <= C_PHASE_RST;
      tick_count_q <= '0;
      step_q       <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      phase_q      <= phase_d;
      tick_count_q <= tick_count_d;
      step_q       <= step_d;
      running_q    <= running_d;
      halted_q     <= halted_d;
    end
  end

  assign tick       = tick_q;
  assign phase      = phase_q;
  assign tick_count = tick_count_q;
  assign running    = running_q;
  assign halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_ctrl
// Brief    : Self-checking bench for clock_ctrl. Two instances (2 and 4
//            phases) share stimulus; a behavioural model checks every cycle,
//            a vector table and short sequences pin down the corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_ctrl;

  localparam int DIV_W = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, enable, step, halt, clear_halt;
  logic [DIV_W-1:0] div;

  logic             tick2, tick4;
  logic [1:0]       phase2;
  logic [3:0]       phase4;
  logic [CNT_W-1:0] cnt2, cnt4;
  logic             run2, run4, hlt2, hlt4;

  clock_ctrl #(.DIV_W(DIV_W), .PHASES(2), .CNT_W(CNT_W)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .step(step), .halt(halt),
    .clear_halt(clear_halt), .div(div), .tick(tick2), .phase(phase2),
    .tick_count(cnt2), .running(run2), .halted(hlt2)
  );

  clock_ctrl #(.DIV_W(DIV_W), .PHASES(4), .CNT_W(CNT_W)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .step(step), .halt(halt),
    .clear_halt(clear_halt), .div(div), .tick(tick4), .phase(phase4),
    .tick_count(cnt4), .running(run4), .halted(hlt4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Mode: 0 idle, 1 run, 2 halted. Phase is derived from the total number
  // of completed ticks, so the ring is position = ticks mod PHASES.
  int m_mode;
  int m_cnt;
  int m_ticks;
  bit m_tick;
  bit m_prev_step;

  task automatic model_edge();
    bit new_tick;
    int next_mode;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_ticks = 0; m_tick = 0; m_prev_step = 0;
      return;
    end
    if (halt)            next_mode = 2;
    else if (m_mode == 2) next_mode = clear_halt ? 0 : 2;
    else                  next_mode = enable ? 1 : 0;

    new_tick = 0;
    if (m_mode == 1)
      new_tick = (m_cnt >= int'(div));
    else if (m_mode == 0 && !enable && step && !m_prev_step)
      new_tick = 1;
    if (halt) new_tick = 0;

    if (m_mode == 1 && next_mode == 1)
      m_cnt = (m_cnt >= int'(div)) ? 0 : m_cnt + 1;
    else
      m_cnt = 0;

    if (m_tick) m_ticks++;
    m_tick      = new_tick;
    m_prev_step = step;
    m_mode      = next_mode;
  endtask

  // One clock: model follows the edge, both DUTs are compared 1 time unit later
  task automatic cycle();
    logic [31:0] exp_cnt;
    @(posedge clk);
    model_edge();
    #1;
    exp_cnt = 32'(m_ticks % 65536);
    check("model_tick2",    32'(tick2),  32'(m_tick));
    check("model_phase2",   32'(phase2), 32'(1) << (m_ticks % 2));
    check("model_count2",   32'(cnt2),   exp_cnt);
    check("model_running2", 32'(run2),   32'(m_mode == 1));
    check("model_halted2",  32'(hlt2),   32'(m_mode == 2));
    check("model_tick4",    32'(tick4),  32'(m_tick));
    check("model_phase4",   32'(phase4), 32'(1) << (m_ticks % 4));
    check("model_count4",   32'(cnt4),   exp_cnt);
    check("model_running4", 32'(run4),   32'(m_mode == 1));
    check("model_halted4",  32'(hlt4),   32'(m_mode == 2));
  endtask

  task automatic drive(input bit r, input bit e, input bit s, input bit h,
                       input bit c, input int d);
    rst = r; enable = e; step = s; halt = h; clear_halt = c; div = DIV_W'(d);
  endtask

  // ---------------- vector table: reset then free-run, div=3 ----------------
  typedef struct {
    bit         rst;
    bit         en;
    int         div;
    bit         exp_tick;
    logic [1:0] exp_phase;
    int         exp_cnt;
    bit         exp_run;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int nt;
    drive(1, 0, 0, 0, 0, 0);

    vecs[0]  = '{1, 1, 3, 0, 2'b01, 0, 0};
    vecs[1]  = '{1, 1, 3, 0, 2'b01, 0, 0};
    vecs[2]  = '{0, 1, 3, 0, 2'b01, 0, 1};
    vecs[3]  = '{0, 1, 3, 0, 2'b01, 0, 1};
    vecs[4]  = '{0, 1, 3, 0, 2'b01, 0, 1};
    vecs[5]  = '{0, 1, 3, 0, 2'b01, 0, 1};
    vecs[6]  = '{0, 1, 3, 1, 2'b01, 0, 1};
    vecs[7]  = '{0, 1, 3, 0, 2'b10, 1, 1};
    vecs[8]  = '{0, 1, 3, 0, 2'b10, 1, 1};
    vecs[9]  = '{0, 1, 3, 0, 2'b10, 1, 1};
    vecs[10] = '{0, 1, 3, 1, 2'b10, 1, 1};
    vecs[11] = '{0, 1, 3, 0, 2'b01, 2, 1};
    vecs[12] = '{0, 1, 3, 0, 2'b01, 2, 1};
    vecs[13] = '{0, 1, 3, 0, 2'b01, 2, 1};
    vecs[14] = '{0, 1, 3, 1, 2'b01, 2, 1};
    vecs[15] = '{0, 1, 3, 0, 2'b10, 3, 1};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].en, 0, 0, 0, vecs[i].div);
      cycle();
      check($sformatf("vec%0d_tick", i),    32'(tick2),  32'(vecs[i].exp_tick));
      check($sformatf("vec%0d_phase", i),   32'(phase2), 32'(vecs[i].exp_phase));
      check($sformatf("vec%0d_count", i),   32'(cnt2),   32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_running", i), 32'(run2),   32'(vecs[i].exp_run));
      check($sformatf("vec%0d_halted", i),  32'(hlt2),   32'(0));
    end

    // ---------------- divide-by-one with 4-phase wrap ----------------
    drive(1, 0, 0, 0, 0, 0); cycle();
    drive(0, 1, 0, 0, 0, 0); cycle();
    check("div1_entry_tick", 32'(tick4), 32'(0));
    for (int i = 0; i < 6; i++) begin
      cycle();
      check($sformatf("div1_tick%0d", i),  32'(tick4),  32'(1));
      check($sformatf("div1_phase%0d", i), 32'(phase4), 32'(1) << (i % 4));
    end

    // ---------------- single step, step held high ----------------
    drive(1, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 1, 0, 0, 0);
    nt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i == 0) check("step_latency", 32'(tick2), 32'(1));
      nt += int'(tick2);
    end
    check("step_held_once", 32'(nt), 32'(1));
    drive(0, 0, 0, 0, 0, 0); cycle();
    check("step_count1", 32'(cnt2), 32'(1));
    drive(0, 0, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle(); cycle();
    check("step_count2", 32'(cnt2), 32'(2));

    // ---------------- halt / resume, div=1 ----------------
    drive(1, 0, 0, 0, 0, 0); cycle();
    drive(0, 1, 0, 0, 0, 1); cycle();  // RUN entry
    cycle();
    cycle();
    check("halt_pre_tick", 32'(tick2), 32'(1));
    cycle();                           // mid-period
    drive(0, 1, 0, 1, 0, 1); cycle();  // tick would be due here
    check("halt_tick_dropped", 32'(tick2), 32'(0));
    check("halt_halted", 32'(hlt2), 32'(1));
    drive(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(0, 1, 0, 1, 1, 1); // halt and clear together
      cycle();
      check($sformatf("halt_stay%0d", i), 32'(hlt2), 32'(1));
      check($sformatf("halt_notick%0d", i), 32'(tick2), 32'(0));
    end
    drive(0, 1, 0, 0, 1, 1); cycle();
    check("clear_halted", 32'(hlt2), 32'(0));
    check("clear_not_running", 32'(run2), 32'(0));
    drive(0, 1, 0, 0, 0, 1); cycle();
    check("resume_running", 32'(run2), 32'(1));
    cycle();
    check("resume_gap", 32'(tick2), 32'(0));
    cycle();
    check("resume_first_tick", 32'(tick2), 32'(1));

    // ---------------- live divisor change ----------------
    drive(1, 0, 0, 0, 0, 10); cycle();
    drive(0, 1, 0, 0, 0, 10); cycle();
    for (int i = 0; i < 7; i++) begin
      cycle();
      check($sformatf("live_wait%0d", i), 32'(tick2), 32'(0));
    end
    drive(0, 1, 0, 0, 0, 2);
    for (int i = 0; i < 9; i++) begin
      cycle();
      check($sformatf("live_tick%0d", i), 32'(tick2), 32'(i % 3 == 0));
    end

    // ---------------- reset when a tick is due ----------------
    drive(1, 0, 0, 0, 0, 1); cycle();
    drive(0, 1, 0, 0, 0, 1); cycle();
    cycle(); cycle();
    check("rstmid_tick", 32'(tick2), 32'(1));
    cycle();
    check("rstmid_phase_moved", 32'(phase2), 32'(2));
    drive(1, 1, 0, 0, 0, 1); cycle();
    check("rstmid_tick0", 32'(tick2), 32'(0));
    check("rstmid_phase1", 32'(phase2), 32'(1));
    check("rstmid_count0", 32'(cnt2), 32'(0));
    check("rstmid_idle", 32'({run2, hlt2}), 32'(0));
    drive(0, 1, 0, 0, 0, 1); cycle();
    check("rstmid_rerun", 32'(run2), 32'(1));

    // ---------------- step edge together with enable rising ----------------
    drive(1, 0, 0, 0, 0, 4); cycle();
    drive(0, 0, 0, 0, 0, 4); cycle();
    drive(0, 1, 1, 0, 0, 4); cycle();
    check("step_en_notick", 32'(tick2), 32'(0));
    check("step_en_running", 32'(run2), 32'(1));

    // ---------------- randomized stimulus vs model ----------------
    drive(1, 0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 3000; i++) begin
      bit r, e, s, h, c;
      int d;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 7) != 0);
      s = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 24) == 0);
      c = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : int'(div);
      if ($urandom_range(0, 299) == 0) d = int'($urandom_range(0, 65535));
      if (d > 5 && $urandom_range(0, 9) == 0) d = int'($urandom_range(0, 5));
      drive(r, e, s, h, c, d);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
